// File: rtl/kd_arith_pkg.sv
// Shared arithmetic definitions for the Karatsuba multiplier and divider.
// Holds the FSM state encoding and the default operand width.
package kd_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } kd_state_e;

    localparam int KD_W = 32;

    localparam logic [KD_W-1:0] KD_Q_ONES = '1;

endpackage

// File: rtl/kd_div_step.sv
// One-bit restoring division step.
// Shifts the next dividend bit into the partial remainder and subtracts the divisor when it fits.
module kd_div_step
    import kd_arith_pkg::*;
#(
    parameter int W = KD_W
) (
    input  logic [W-1:0] r_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] r_o,
    output logic         q_o
);

    logic [W:0] t;

    always_comb begin
        t   = {r_i, bit_i};
        q_o = (t >= {1'b0, divisor_i});
        // r_i < divisor, so the difference always fits in W bits
        r_o = q_o ? (t[W-1:0] - divisor_i) : t[W-1:0];
    end

endmodule

// File: rtl/kd_divider_64by32.sv
// Sequential 2W-by-W restoring divider with valid/ready handshakes.
// One division in flight; W iterations per normal result.
module kd_divider_64by32
    import kd_arith_pkg::*;
#(
    parameter int W = KD_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    kd_state_e     state_q, state_d;
    logic [W-1:0]  r_q, r_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [W-1:0]  step_r;
    logic          step_q;

    kd_div_step #(.W(W)) u_step (
        .r_i       (r_q),
        .bit_i     (q_q[W-1]),
        .divisor_i (dvs_q),
        .r_o       (step_r),
        .q_o       (step_q)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    if (divisor == '0) begin
                        dbz_d   = 1'b1;
                        q_d     = '1;
                        r_d     = dividend[W-1:0];
                        state_d = DONE;
                    end else if (dividend[2*W-1:W] >= divisor) begin
                        ovf_d   = 1'b1;
                        q_d     = '1;
                        r_d     = dividend[W-1:0];
                        state_d = DONE;
                    end else begin
                        r_d     = dividend[2*W-1:W];
                        q_d     = dividend[W-1:0];
                        cnt_d   = CW'(W - 1);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d = step_r;
                q_d = {q_q[W-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = q_q;
    assign remainder   = r_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
